// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble sequencing, run/halt state and counters for the 5-stage Y86-64 pipe
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             W_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic             mem_fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] AOK     = 3'd1;
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] MEMWAIT = 2'd1;
    localparam logic [1:0] HALT    = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [1:0] state, nextState;
    logic [7:0] waitCnt;
    logic       freeze, excM, excW, loadUse, mispred, retHaz, retire, faultNext;

    assign freeze  = state != HALT && mem_req && !mem_ready;
    assign excM    = m_stat != AOK;
    assign excW    = W_stat != AOK;
    assign loadUse = (E_icode == IMRMOVQ || E_icode == IPOPQ) && E_dstM != RNONE
                     && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign mispred = E_icode == IJXX && !e_Cnd;
    assign retHaz  = D_icode == IRET || E_icode == IRET || M_icode == IRET;
    assign retire  = !W_stall && !W_bubble && W_stat == AOK && W_icode != INOP;

    // Stage controls: reset bubbles, halt freezes, dmem wait overrides hazards, else OR of hazards
    always_comb begin
        {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc} = 8'b0;
        if (!rst_n) begin
            {D_bubble, E_bubble, M_bubble, W_bubble} = 4'b1111;
        end else if (state == HALT) begin
            {F_stall, D_stall, W_stall, M_bubble} = 4'b1111;
        end else if (freeze) begin
            {F_stall, D_stall, W_bubble} = 3'b111;
        end else begin
            F_stall  = loadUse || retHaz;
            D_stall  = loadUse;
            D_bubble = (mispred || retHaz) && !loadUse;
            E_bubble = loadUse || mispred;
            M_bubble = excM || excW;
            W_stall  = excW;
            set_cc   = !excM && !excW && !(loadUse || mispred);
        end
    end

    // Next run state and whether this cycle ends in a dmem timeout
    always_comb begin
        nextState = state;
        faultNext = 1'b0;
        if (state == RUN) begin
            nextState = excW ? HALT : (mem_req && !mem_ready) ? MEMWAIT : RUN;
        end else if (state == MEMWAIT) begin
            faultNext = !mem_ready && waitCnt == WAIT_LAST;
            nextState = mem_ready ? RUN : faultNext ? HALT : MEMWAIT;
        end
    end

    // State, wait timer, status flags and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            waitCnt     <= '0;
            halted      <= 1'b0;
            mem_fault   <= 1'b0;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            state       <= nextState;
            waitCnt     <= freeze ? waitCnt + 8'd1 : mem_ready ? 8'd0 : waitCnt;
            halted      <= nextState == HALT;
            mem_fault   <= mem_fault || faultNext;
            cycle_cnt   <= state != HALT ? cycle_cnt + 1'b1 : cycle_cnt;
            retired_cnt <= retire ? retired_cnt + 1'b1 : retired_cnt;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard controls, dmem freeze/timeout, halt and counters
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic        e_Cnd, mem_req, mem_ready;
    logic [2:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc;
    logic        halted, mem_fault;
    logic [31:0] cycle_cnt, retired_cnt;
    logic [7:0]  ctl;
    int          compared = 0;
    int          mismatched = 0;
    int          expCyc = 0;
    int          expRet = 0;
    bit          expHalt = 0;

    pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat), .mem_req(mem_req), .mem_ready(mem_ready),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .W_bubble(W_bubble), .set_cc(set_cc),
        .halted(halted), .mem_fault(mem_fault), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
        m_stat = 3'd1; W_stat = 3'd1; mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!expHalt) expCyc++;
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        settle();
        chk("reset_ctl", ctl, 8'b00111010);
        chk("reset_halted", {halted, mem_fault}, 2'b00);
        chk("reset_cycle", cycle_cnt, 0);
        chk("reset_retired", retired_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        chk("idle_ctl", ctl, 8'b00000001);
        chk("idle_cycle", cycle_cnt, 0);
        // load-use on srcA, srcB, and RNONE destination
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        settle();
        chk("loaduse_a", ctl[7:1], 7'b1101000);
        cyc();
        idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        settle();
        chk("loaduse_b", ctl[7:1], 7'b1101000);
        cyc();
        idle(); E_icode = 4'h5;
        settle();
        chk("loaduse_rnone", ctl, 8'b00000001);
        cyc();
        // mispredict taken / not taken
        idle(); E_icode = 4'h7; e_Cnd = 1'b0;
        settle();
        chk("mispred", ctl[7:1], 7'b0011000);
        e_Cnd = 1'b1;
        settle();
        chk("jxx_taken", ctl, 8'b00000001);
        cyc();
        // ret walking D -> E -> M
        idle(); D_icode = 4'h9;
        settle();
        chk("ret_d", ctl[7:1], 7'b1010000);
        cyc();
        idle(); E_icode = 4'h9;
        settle();
        chk("ret_e", ctl[7:1], 7'b1010000);
        cyc();
        idle(); M_icode = 4'h9;
        settle();
        chk("ret_m", ctl[7:1], 7'b1010000);
        cyc();
        idle();
        settle();
        chk("ret_done", ctl, 8'b00000001);
        cyc();
        // load-use combined with ret gives stall, not bubble
        D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        settle();
        chk("loaduse_ret", ctl[7:1], 7'b1101000);
        cyc();
        // one retiring instruction
        idle(); W_icode = 4'h6;
        settle();
        chk("retire_ctl", ctl, 8'b00000001);
        cyc(); expRet++;
        chk("retired_1", retired_cnt, expRet);
        // dmem freeze for 3 cycles, overriding a load-use hazard
        mem_req = 1'b1; mem_ready = 1'b0; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("freeze_ctl", ctl, 8'b11000010);
            cyc();
        end
        chk("freeze_retired", retired_cnt, expRet);
        idle(); W_icode = 4'h6; mem_req = 1'b1;
        settle();
        chk("freeze_release", ctl, 8'b00000001);
        cyc(); expRet++;
        chk("retired_2", retired_cnt, expRet);
        chk("cycle_run", cycle_cnt, expCyc);
        // timeout: 15 wait cycles stay alive, the 16th halts
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc();
        settle();
        chk("timeout_edge_halted", {halted, mem_fault}, 2'b00);
        chk("timeout_edge_ctl", ctl, 8'b11000010);
        cyc(); expHalt = 1;
        settle();
        chk("timeout_flags", {halted, mem_fault}, 2'b11);
        chk("halt_ctl", ctl, 8'b11001100);
        mem_ready = 1'b1;
        cyc(); cyc();
        chk("halt_absorbing", halted, 1'b1);
        chk("halt_cycle_frozen", cycle_cnt, expCyc);
        chk("halt_retired", retired_cnt, expRet);
        // reset mid-halt
        rst_n = 1'b0; idle();
        settle();
        chk("rst_mid_ctl", ctl, 8'b00111010);
        chk("rst_mid_flags", {halted, mem_fault}, 2'b00);
        chk("rst_mid_cycle", cycle_cnt, 0);
        chk("rst_mid_retired", retired_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expCyc = 0; expRet = 0; expHalt = 0;
        // exception in M, then in W
        m_stat = 3'd3;
        settle();
        chk("exc_m", ctl, 8'b00001000);
        cyc();
        m_stat = 3'd1; W_stat = 3'd3; W_icode = 4'h6;
        settle();
        chk("exc_w", ctl, 8'b00001100);
        cyc(); expHalt = 1;
        settle();
        chk("exc_flags", {halted, mem_fault}, 2'b10);
        chk("exc_retired", retired_cnt, 0);
        chk("exc_cycle", cycle_cnt, expCyc);
        rst_n = 1'b0;
        settle();
        chk("rst_halt_flags", {halted, mem_fault}, 2'b00);
        chk("rst_halt_cycle", cycle_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1; idle();
        settle();
        chk("rst_halt_run", ctl, 8'b00000001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
